// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - 6x6 unsigned sequential shift-and-add multiplier with a 12-bit product
// Optional MULT_EARLY_EXIT_EN: stop iterating once the remaining multiplier bits are zero.
module shift_add_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  a_in,
    input  logic [5:0]  b_in,
    output logic [11:0] product,
    output logic        done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TEST  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [11:0] mx;
    logic [5:0]  b;
    logic [11:0] p;
    logic [2:0]  cnt;
    logic        last_iter;

`ifdef MULT_EARLY_EXIT_EN
    assign last_iter = (b[5:1] == 5'd0) || (cnt == 3'd5);
`else
    assign last_iter = (cnt == 3'd5);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_TEST;
            S_TEST:  state_next = b[0] ? S_ADD : S_SHIFT;
            S_ADD:   state_next = S_SHIFT;
            S_SHIFT: state_next = last_iter ? S_DONE : S_TEST;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Product is written on the edge into DONE so it is already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            mx      <= 12'd0;
            b       <= 6'd0;
            p       <= 12'd0;
            cnt     <= 3'd0;
            product <= 12'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mx  <= {6'd0, a_in};
                        b   <= b_in;
                        p   <= 12'd0;
                        cnt <= 3'd0;
                    end
                end
                S_ADD: begin
                    p <= p + mx;
                end
                S_SHIFT: begin
                    mx  <= mx << 1;
                    b   <= b >> 1;
                    cnt <= cnt + 3'd1;
                    if (last_iter) begin
                        product <= p;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign done = (state == S_DONE);
    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier (honours MULT_EARLY_EXIT_EN)
module tb_shift_add_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  a_in;
    logic [5:0]  b_in;
    logic [11:0] product;
    logic        done;
    logic        busy;

    int          tests;
    int          fails;
    logic [11:0] exp_q[$];

    shift_add_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_latency(input logic [5:0] bv);
        int pop;
        int k;
        pop = $countones(bv);
`ifdef MULT_EARLY_EXIT_EN
        k = 1;
        for (int i = 0; i < 6; i++) begin
            if (bv[i]) k = i + 1;
        end
        return 2 * k + pop + 1;
`else
        k = 6;
        return 2 * k + pop + 1;
`endif
    endfunction

    // Scoreboard: every done pulse consumes one expected product.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("product", product, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy !== 1'b0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (w >= 60) chk("idle_timeout", 1, 0);
    endtask

    task automatic run_op(input logic [5:0] av, input logic [5:0] bv);
        int   lat;
        logic busy_ok;
        wait_idle();
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        exp_q.push_back(12'(av) * 12'(bv));
        @(posedge clk);
        #1 start = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk($sformatf("latency_%0dx%0d", av, bv), lat, exp_latency(bv));
        chk($sformatf("busy_%0dx%0d", av, bv), busy_ok, 1);
    endtask

    initial begin
        int done_cnt;
        int w;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b1;
        a_in  = 6'd0;
        b_in  = 6'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_product", product, 0);
        chk("reset_done", done, 0);
        chk("reset_busy_start_priority", busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        start  = 1'b0;

        run_op(6'd63, 6'd63);
        run_op(6'd5, 6'd6);
        run_op(6'd0, 6'd0);
        run_op(6'd1, 6'd32);
        run_op(6'd42, 6'd1);
        run_op(6'd63, 6'd63);
        repeat (4) @(negedge clk);
        chk("product_hold", product, 3969);

        // Start ignored while busy, operand changes after capture have no effect.
        wait_idle();
        a_in  = 6'd7;
        b_in  = 6'd9;
        start = 1'b1;
        exp_q.push_back(12'd63);
        @(posedge clk);
        #1 start = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 3) begin
                start = 1'b1;
                a_in  = 6'd2;
                b_in  = 6'd2;
            end
            if (n == 4) begin
                start = 1'b0;
                a_in  = 6'd60;
                b_in  = 6'd61;
            end
            if (done === 1'b1) done_cnt++;
        end
        chk("single_done_busy_start", done_cnt, 1);

        // Abort mid-operation.
        wait_idle();
        a_in  = 6'd63;
        b_in  = 6'd63;
        start = 1'b1;
        exp_q.push_back(12'd3969);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        chk("abort_done", done, 0);
        repeat (25) @(negedge clk);
        run_op(6'd3, 6'd4);

        // Exhaustive sweep with start held high.
        start = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            a_in = 6'(i >> 6);
            b_in = 6'(i);
            w    = 0;
            @(negedge clk);
            while (busy !== 1'b0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40) begin
                chk("sweep_timeout", 1, 0);
                break;
            end
            exp_q.push_back(12'(a_in) * 12'(b_in));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        w = 0;
        while (exp_q.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk("sweep_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 SHALL expose parameter-free fixed widths: 6-bit operands, 12-bit product.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin; sampled only in IDLE.
REQ-005 SHALL have port: a_in  input  6  unsigned multiplicand, captured on accepted start.
REQ-006 SHALL have port: b_in  input  6  unsigned multiplier, captured on accepted start.
REQ-007 SHALL have port: product  output  12  registered result; holds until next completion.
REQ-008 SHALL have port: done  output  1  one-cycle completion pulse, Moore-decoded from DONE state.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL keep internal registers: Mx (12b multiplicand, shifts left), B (6b multiplier, shifts right), P (12b accumulator), cnt (3b iteration counter).
REQ-011 SHALL implement states IDLE, TEST, ADD, SHIFT, DONE; default/illegal encoding -> IDLE.
REQ-012 IDLE: on edge with start=1, SHALL load Mx<={6'b0,a_in}, B<=b_in, P<=0, cnt<=0, go TEST; start=0 stays IDLE.
REQ-013 TEST: SHALL go ADD if B[0]=1, else SHIFT; no register change.
REQ-014 ADD: SHALL load P<=P+Mx (12-bit, cannot overflow for 6x6 operands), go SHIFT.
REQ-015 SHIFT: SHALL load Mx<=Mx<<1, B<=B>>1, cnt<=cnt+1; go DONE if cnt==5 (sixth iteration), else TEST.
REQ-016 DONE: SHALL assert done=1, copy P into product on the same edge that leaves DONE... product SHALL instead be loaded on the edge entering DONE so it is valid while done=1; go IDLE.
REQ-017 Latency (macro absent): done high in cycle 13+popcount(b_in) after the capture edge (cycle 1 = first TEST).
REQ-018 start asserted while busy=1 SHALL be ignored; a_in/b_in changes after capture SHALL not affect the result.
REQ-019 start held high through DONE SHALL be accepted in the following IDLE cycle (one idle cycle between operations).
REQ-020 product = a_in*b_in exactly for all 4096 operand pairs.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, Mx=B=P=cnt=0, product=0; done=0 and busy=0 the following cycle.
REQ-022 rst mid-operation SHALL abort with no done pulse and product cleared to 0.
REQ-023 rst has priority over start on the same edge.

Configuration
REQ-024 Macro MULT_EARLY_EXIT_EN SHALL, when defined, make SHIFT go DONE when B[5:1]==0 (remaining multiplier bits zero) or cnt==5.
REQ-025 With MULT_EARLY_EXIT_EN: iterations k=max(1, msb index of b_in +1); done high in cycle 2k+popcount(b_in)+1 after capture; product identical to REQ-020.
REQ-026 Without MULT_EARLY_EXIT_EN: always six iterations, latency per REQ-017; no other behavioural difference.

Verification
REQ-027 a_in=63, b_in=63, start one cycle -> product=12'hF81 (3969), done in cycle 19 (both configs), busy high cycles 1-19.
REQ-028 a_in=5, b_in=6 -> product=30; done cycle 15 (macro absent), cycle 9 (MULT_EARLY_EXIT_EN).
REQ-029 a_in=0, b_in=0 -> product=0; done cycle 13 (macro absent), cycle 3 (MULT_EARLY_EXIT_EN); prior nonzero product overwritten.
REQ-030 Start 7x9, pulse start with 2x2 at cycle 4, change a_in/b_in at cycle 5 -> product=63, single done pulse, second start ignored.
REQ-031 Start 63x63, assert rst at cycle 8 -> next cycle IDLE, busy=0, product=0, no done; new start 3x4 afterwards -> product=12.
REQ-032 Exhaustive sweep of all 4096 operand pairs back-to-back with start held high -> every product matches reference multiply, exactly one done per operation.
